// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator keypad sequencer.
//   - state_t   : controller states
//   - KEY_*     : keypad codes for operator / equals / clear keys
//   - DATA_W    : operand/result width of the shared add/sub unit
//   - MAX_DIGITS, MAX_VALUE : decimal entry limits
//   - pow10()   : constant helper for decimal limits
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int DATA_W     = 14;
  localparam int MAX_DIGITS = 4;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int MAX_VALUE = pow10(MAX_DIGITS) - 1;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_EQ  = 4'd12;
  localparam logic [3:0] KEY_CLR = 4'd13;

  typedef enum logic [2:0] {
    ENTER_A,
    OP,
    ENTER_B,
    CALC,
    SHOW,
    ERROR
  } state_t;

endpackage

// File: rtl/calc_if.sv
// -----------------------------------------------------------------------------
// calc_if
// Bundles the keypad handshake, the arithmetic-unit connection and the display
// outputs of calc_controller.
//   slave  : controller side (consumes keys and arith_result, drives the rest)
//   master : environment side (keypad decoder, arithmetic unit, display path)
// -----------------------------------------------------------------------------
interface calc_if #(
  parameter int DATA_W = calc_pkg::DATA_W
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic              key_ready;
  logic [DATA_W-1:0] arith_a;
  logic [DATA_W-1:0] arith_b;
  logic              arith_sel;
  logic [DATA_W-1:0] arith_result;
  logic [DATA_W-1:0] display_value;
  logic              display_neg;
  logic              display_err;

  modport slave (
    input  key_valid, key_code, arith_result,
    output key_ready, arith_a, arith_b, arith_sel,
           display_value, display_neg, display_err
  );

  modport master (
    output key_valid, key_code, arith_result,
    input  key_ready, arith_a, arith_b, arith_sel,
           display_value, display_neg, display_err
  );
endinterface

// File: rtl/calc_digit_accum.sv
// -----------------------------------------------------------------------------
// calc_digit_accum
// One decimal operand register built up from keypad digits.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : zero the operand (highest priority)
//   load_value    : load a full value (result chaining)
//   load_digit    : start a new operand with a single digit
//   append_digit  : op <= op*10 + digit, ignored once MAX_DIGITS are present
//   digit         : digit 0-9
//   value         : value for load_value
//   op            : current operand
// -----------------------------------------------------------------------------
module calc_digit_accum #(
  parameter int DATA_W     = calc_pkg::DATA_W,
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_value,
  input  logic              load_digit,
  input  logic              append_digit,
  input  logic [3:0]        digit,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] op
);
  import calc_pkg::*;

  // 4 extra bits hold op*10 + 9 for any op without truncation
  localparam int                WIDE_W  = DATA_W + 4;
  localparam logic [DATA_W-1:0] LIMIT_W = DATA_W'(pow10(MAX_DIGITS - 1));
  localparam logic [WIDE_W-1:0] MAX_W   = WIDE_W'(pow10(MAX_DIGITS) - 1);

  logic [WIDE_W-1:0] append_w;
  logic              has_room;

  assign append_w = ({4'b0000, op} * WIDE_W'(10)) + {{DATA_W{1'b0}}, digit};
  assign has_room = (op < LIMIT_W) && (append_w <= MAX_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
    end else if (clr) begin
      op <= '0;
    end else if (load_value) begin
      op <= value;
    end else if (load_digit) begin
      op <= {{(DATA_W-4){1'b0}}, digit};
    end else if (append_digit && has_room) begin
      op <= append_w[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/calc_controller.sv
// -----------------------------------------------------------------------------
// calc_controller
// Keypad-driven sequencer for the shared add/sub arithmetic unit. Collects
// operand A, an operator and operand B from the key stream, runs one CALC
// cycle on the arithmetic unit and presents magnitude / sign / error to the
// display path.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : calc_if.slave
//                key_valid/key_code/key_ready  keypad handshake
//                arith_a/arith_b/arith_sel     operands + op to arithmetic unit
//                arith_result                  combinational unit result
//                display_value/neg/err         display outputs
// Build option:
//   CALC_CHAIN_EN - an operator pressed while a non-negative result is shown
//                   reuses that result as operand A.
// -----------------------------------------------------------------------------
module calc_controller #(
  parameter int DATA_W     = calc_pkg::DATA_W,
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
  input  logic   clk,
  input  logic   rst_n,
  calc_if.slave  bus
);
  import calc_pkg::*;

  localparam logic [DATA_W-1:0] MAX_W = DATA_W'(pow10(MAX_DIGITS) - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] result_q;
  logic              neg_q;
  logic              sel_q, sel_d;

  logic accept, is_digit, is_oper, is_eq, is_clr;
  logic a_clr, a_lv, a_ld, a_app;
  logic b_clr, b_ld, b_app;
  logic res_clr, calc_go;

  logic              add_ovf, sub_neg, calc_err;
  logic [DATA_W-1:0] calc_mag;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] xs;
    xs = x;
    return -xs;
  endfunction

  assign accept   = bus.key_valid && bus.key_ready;
  assign is_digit = (bus.key_code <= 4'd9);
  assign is_oper  = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB);
  assign is_eq    = (bus.key_code == KEY_EQ);
  assign is_clr   = (bus.key_code == KEY_CLR);

  // Result evaluation, used only in the CALC cycle. An unsigned sum below
  // opA can only come from a wrap past 2^DATA_W.
  assign add_ovf  = (bus.arith_result < opa) || (bus.arith_result > MAX_W);
  assign sub_neg  = (opa < opb);
  assign calc_err = !sel_q && add_ovf;
  assign calc_mag = (sel_q && sub_neg) ? negate(bus.arith_result) : bus.arith_result;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_clr   = 1'b0;
    a_lv    = 1'b0;
    a_ld    = 1'b0;
    a_app   = 1'b0;
    b_clr   = 1'b0;
    b_ld    = 1'b0;
    b_app   = 1'b0;
    res_clr = 1'b0;
    calc_go = 1'b0;

    if (state_q == CALC) begin
      calc_go = 1'b1;
      state_d = calc_err ? ERROR : SHOW;
    end else if (accept) begin
      if (is_clr) begin
        state_d = ENTER_A;
        a_clr   = 1'b1;
        b_clr   = 1'b1;
        res_clr = 1'b1;
      end else begin
        unique case (state_q)
          ENTER_A: begin
            if (is_digit) begin
              a_app = 1'b1;
            end else if (is_oper) begin
              sel_d   = (bus.key_code == KEY_SUB);
              state_d = OP;
            end
          end
          OP: begin
            if (is_digit) begin
              b_ld    = 1'b1;
              state_d = ENTER_B;
            end else if (is_oper) begin
              sel_d = (bus.key_code == KEY_SUB);
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              b_app = 1'b1;
            end else if (is_eq) begin
              state_d = CALC;
            end
          end
          SHOW: begin
            if (is_digit) begin
              a_ld    = 1'b1;
              b_clr   = 1'b1;
              res_clr = 1'b1;
              state_d = ENTER_A;
            end
`ifdef CALC_CHAIN_EN
            else if (is_oper && !neg_q) begin
              a_lv    = 1'b1;
              b_clr   = 1'b1;
              sel_d   = (bus.key_code == KEY_SUB);
              state_d = OP;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      sel_q    <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (res_clr) begin
        result_q <= '0;
        neg_q    <= 1'b0;
      end else if (calc_go) begin
        result_q <= calc_err ? '0 : calc_mag;
        neg_q    <= !calc_err && sel_q && sub_neg;
      end
    end
  end

  calc_digit_accum #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_opa (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (a_clr),
    .load_value   (a_lv),
    .load_digit   (a_ld),
    .append_digit (a_app),
    .digit        (bus.key_code),
    .value        (result_q),
    .op           (opa)
  );

  calc_digit_accum #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_opb (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (b_clr),
    .load_value   (1'b0),
    .load_digit   (b_ld),
    .append_digit (b_app),
    .digit        (bus.key_code),
    .value        ('0),
    .op           (opb)
  );

  assign bus.key_ready = (state_q != CALC);
  assign bus.arith_a   = opa;
  assign bus.arith_b   = opb;
  assign bus.arith_sel = sel_q;

  always_comb begin
    bus.display_value = '0;
    unique case (state_q)
      ENTER_A, OP: bus.display_value = opa;
      ENTER_B:     bus.display_value = opb;
      CALC:        bus.display_value = opb;
      SHOW:        bus.display_value = result_q;
      default:     bus.display_value = '0;
    endcase
  end

  assign bus.display_neg = (state_q == SHOW) && neg_q;
  assign bus.display_err = (state_q == ERROR);

endmodule

// File: tb/tb_calc_controller.sv
// -----------------------------------------------------------------------------
// tb_calc_controller
// Drives calc_controller with directed and random key streams, models the
// arithmetic unit combinationally and compares against a key-level
// calculator model. Honours CALC_CHAIN_EN.
// -----------------------------------------------------------------------------
module tb_calc_controller;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  calc_if bus ();

  // Arithmetic unit: plain add/sub, wraps at DATA_W bits.
  assign bus.arith_result = bus.arith_sel ? (bus.arith_a - bus.arith_b)
                                          : (bus.arith_a + bus.arith_b);

  calc_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- calculator model (key level) ----------------
  localparam int MD_A = 0, MD_OP = 1, MD_B = 2, MD_SHOW = 3, MD_ERR = 4;
  int m_mode, ma, mb, m_val;
  bit m_sub, m_neg;

  function automatic void model_reset();
    m_mode = MD_A; ma = 0; mb = 0; m_val = 0; m_sub = 0; m_neg = 0;
  endfunction

  // Returns 1 when the key starts a computation.
  function automatic bit model_key(input int code);
    int r;
    model_key = 0;
    if (code == 13) begin
      m_mode = MD_A; ma = 0; mb = 0; m_val = 0; m_neg = 0;
    end else if (code <= 9) begin
      case (m_mode)
        MD_A:    if (ma < 1000) ma = ma * 10 + code;
        MD_OP:   begin mb = code; m_mode = MD_B; end
        MD_B:    if (mb < 1000) mb = mb * 10 + code;
        MD_SHOW: begin ma = code; mb = 0; m_val = 0; m_neg = 0; m_mode = MD_A; end
        default: ;
      endcase
    end else if (code == 10 || code == 11) begin
      case (m_mode)
        MD_A, MD_OP: begin m_sub = (code == 11); m_mode = MD_OP; end
`ifdef CALC_CHAIN_EN
        MD_SHOW: if (!m_neg) begin
          ma = m_val; mb = 0; m_sub = (code == 11); m_mode = MD_OP;
        end
`endif
        default: ;
      endcase
    end else if (code == 12 && m_mode == MD_B) begin
      model_key = 1;
      r = m_sub ? ma - mb : ma + mb;
      if (!m_sub && r > MAX_VALUE) begin
        m_mode = MD_ERR; m_val = 0; m_neg = 0;
      end else begin
        m_mode = MD_SHOW; m_neg = (r < 0); m_val = (r < 0) ? -r : r;
      end
    end
  endfunction

  function automatic int exp_value();
    case (m_mode)
      MD_A, MD_OP: return ma;
      MD_B:        return mb;
      MD_SHOW:     return m_val;
      default:     return 0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_key(input int code, output bit went_calc);
    int guard;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    guard = 0;
    while (bus.key_ready !== 1'b1 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 8) begin
      n_total++;
      $display("FAIL key_ready_timeout: key_ready=%b required 1 within 8 cycles", bus.key_ready);
    end
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    went_calc = model_key(code);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_total++;
    if (bus.display_value !== 14'd0 || bus.display_neg !== 1'b0 || bus.display_err !== 1'b0 ||
        bus.key_ready !== 1'b1 || bus.arith_a !== 14'd0 || bus.arith_b !== 14'd0 ||
        bus.arith_sel !== 1'b0)
      $display("FAIL reset: val=%0d neg=%b err=%b rdy=%b a=%0d b=%0d sel=%b required 0 0 0 1 0 0 0",
               bus.display_value, bus.display_neg, bus.display_err, bus.key_ready,
               bus.arith_a, bus.arith_b, bus.arith_sel);
    else n_pass++;
  endtask

  task automatic test_add();
    bit c;
    int seq[6] = '{1, 2, 10, 3, 4, 12};
    foreach (seq[i]) send_key(seq[i], c);
    n_total++;
    if (bus.key_ready !== 1'b0 || bus.arith_a !== 14'd12 || bus.arith_b !== 14'd34 ||
        bus.arith_sel !== 1'b0)
      $display("FAIL add_calc: rdy=%b a=%0d b=%0d sel=%b required 0 12 34 0",
               bus.key_ready, bus.arith_a, bus.arith_b, bus.arith_sel);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.display_value !== 14'd46 || bus.display_neg !== 1'b0 || bus.display_err !== 1'b0 ||
        bus.key_ready !== 1'b1)
      $display("FAIL add_show: val=%0d neg=%b err=%b rdy=%b required 46 0 0 1",
               bus.display_value, bus.display_neg, bus.display_err, bus.key_ready);
    else n_pass++;
  endtask

  task automatic test_sub_neg();
    bit c;
    int seq[4] = '{5, 11, 9, 12};
    foreach (seq[i]) send_key(seq[i], c);
    n_total++;
    if (bus.key_ready !== 1'b0 || bus.arith_a !== 14'd5 || bus.arith_b !== 14'd9 ||
        bus.arith_sel !== 1'b1)
      $display("FAIL sub_calc: rdy=%b a=%0d b=%0d sel=%b required 0 5 9 1",
               bus.key_ready, bus.arith_a, bus.arith_b, bus.arith_sel);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.display_value !== 14'd4 || bus.display_neg !== 1'b1 || bus.display_err !== 1'b0)
      $display("FAIL sub_show: val=%0d neg=%b err=%b required 4 1 0",
               bus.display_value, bus.display_neg, bus.display_err);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit c;
    int seq[10] = '{9, 9, 9, 9, 10, 9, 9, 9, 9, 12};
    foreach (seq[i]) send_key(seq[i], c);
    @(posedge clk); #1;
    n_total++;
    if (bus.display_value !== 14'd0 || bus.display_err !== 1'b1 || bus.display_neg !== 1'b0)
      $display("FAIL ovf_err: val=%0d err=%b neg=%b required 0 1 0",
               bus.display_value, bus.display_err, bus.display_neg);
    else n_pass++;
    send_key(7, c);
    n_total++;
    if (bus.display_value !== 14'd0 || bus.display_err !== 1'b1)
      $display("FAIL ovf_digit_ignored: val=%0d err=%b required 0 1",
               bus.display_value, bus.display_err);
    else n_pass++;
    send_key(13, c);
    n_total++;
    if (bus.display_value !== 14'd0 || bus.display_err !== 1'b0 || bus.key_ready !== 1'b1)
      $display("FAIL ovf_clear: val=%0d err=%b rdy=%b required 0 0 1",
               bus.display_value, bus.display_err, bus.key_ready);
    else n_pass++;
    send_key(8, c);
    n_total++;
    if (bus.display_value !== 14'd8)
      $display("FAIL ovf_clear_enter_a: val=%0d required 8", bus.display_value);
    else n_pass++;
    send_key(13, c);
  endtask

  task automatic test_digit_limit();
    bit c;
    int seq[5] = '{1, 2, 3, 4, 5};
    foreach (seq[i]) send_key(seq[i], c);
    n_total++;
    if (bus.display_value !== 14'd1234)
      $display("FAIL digit_limit: val=%0d required 1234", bus.display_value);
    else n_pass++;
    send_key(14, c);
    send_key(12, c);
    send_key(15, c);
    n_total++;
    if (bus.display_value !== 14'd1234 || bus.key_ready !== 1'b1 || bus.display_err !== 1'b0)
      $display("FAIL ignored_keys: val=%0d rdy=%b err=%b required 1234 1 0",
               bus.display_value, bus.key_ready, bus.display_err);
    else n_pass++;
    send_key(13, c);
  endtask

  task automatic test_chain();
    bit c;
    int seq[6] = '{1, 2, 10, 3, 4, 12};
    foreach (seq[i]) send_key(seq[i], c);
    @(posedge clk); #1;
    send_key(11, c);
    send_key(6, c);
    send_key(12, c);
`ifdef CALC_CHAIN_EN
    n_total++;
    if (bus.arith_a !== 14'd46 || bus.arith_b !== 14'd6 || bus.arith_sel !== 1'b1 ||
        bus.key_ready !== 1'b0)
      $display("FAIL chain_calc: a=%0d b=%0d sel=%b rdy=%b required 46 6 1 0",
               bus.arith_a, bus.arith_b, bus.arith_sel, bus.key_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.display_value !== 14'd40 || bus.display_neg !== 1'b0)
      $display("FAIL chain_show: val=%0d neg=%b required 40 0", bus.display_value, bus.display_neg);
    else n_pass++;
`else
    n_total++;
    if (bus.display_value !== 14'd6 || bus.display_neg !== 1'b0 || bus.key_ready !== 1'b1)
      $display("FAIL chain_off: val=%0d neg=%b rdy=%b required 6 0 1",
               bus.display_value, bus.display_neg, bus.key_ready);
    else n_pass++;
`endif
    send_key(13, c);
  endtask

  task automatic test_back_to_back();
    bit c;
    int seq[4] = '{1, 10, 2, 12};
    foreach (seq[i]) send_key(seq[i], c);
    n_total++;
    if (bus.key_ready !== 1'b0)
      $display("FAIL b2b_busy: rdy=%b required 0", bus.key_ready);
    else n_pass++;
    send_key(3, c);
    n_total++;
    if (bus.display_value !== 14'd3 || bus.display_neg !== 1'b0 || bus.key_ready !== 1'b1)
      $display("FAIL b2b_next: val=%0d neg=%b rdy=%b required 3 0 1",
               bus.display_value, bus.display_neg, bus.key_ready);
    else n_pass++;
    send_key(13, c);
  endtask

  task automatic test_reset_mid_calc();
    bit c;
    int seq[4] = '{7, 10, 8, 12};
    foreach (seq[i]) send_key(seq[i], c);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.key_ready !== 1'b1 || bus.display_value !== 14'd0 || bus.arith_a !== 14'd0 ||
        bus.arith_b !== 14'd0 || bus.arith_sel !== 1'b0)
      $display("FAIL reset_mid_calc: rdy=%b val=%0d a=%0d b=%0d sel=%b required 1 0 0 0 0",
               bus.key_ready, bus.display_value, bus.arith_a, bus.arith_b, bus.arith_sel);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bus.display_value !== 14'd0 || bus.display_neg !== 1'b0 || bus.display_err !== 1'b0)
      $display("FAIL reset_no_result: val=%0d neg=%b err=%b required 0 0 0",
               bus.display_value, bus.display_neg, bus.display_err);
    else n_pass++;
  endtask

  task automatic test_random();
    bit c;
    int code, pick;
    for (int k = 0; k < 400; k++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 60)      code = int'($urandom_range(0, 9));
      else if (pick < 74) code = int'($urandom_range(10, 11));
      else if (pick < 90) code = 12;
      else if (pick < 95) code = 13;
      else                code = int'($urandom_range(14, 15));
      send_key(code, c);
      if (c) begin
        n_total++;
        if (bus.key_ready !== 1'b0 || bus.arith_a !== DATA_W'(ma) ||
            bus.arith_b !== DATA_W'(mb) || bus.arith_sel !== m_sub)
          $display("FAIL rand_calc[%0d]: rdy=%b a=%0d b=%0d sel=%b required 0 %0d %0d %b",
                   k, bus.key_ready, bus.arith_a, bus.arith_b, bus.arith_sel, ma, mb, m_sub);
        else n_pass++;
        @(posedge clk); #1;
      end
      n_total++;
      if (bus.display_value !== DATA_W'(exp_value()) || bus.display_neg !== m_neg ||
          bus.display_err !== (m_mode == MD_ERR))
        $display("FAIL rand_disp[%0d] key=%0d: val=%0d neg=%b err=%b required %0d %b %b",
                 k, code, bus.display_value, bus.display_neg, bus.display_err,
                 exp_value(), m_neg, (m_mode == MD_ERR));
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_add();
    test_sub_neg();
    test_overflow();
    test_digit_limit();
    test_chain();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
